// File: rtl/ca_code_pkg.sv
// Shared constants, types and the PRN tap lookup for the GPS C/A code generator.
package ca_code_pkg;

   localparam int unsigned CA_LEN = 1023;
   localparam logic [10:1] LfsrInit = 10'h3ff;

   typedef struct packed {
      logic       valid;
      logic [3:0] a;
      logic [3:0] b;
   } tap_pair_t;

   typedef enum logic {StIdle, StSlew} slew_state_e;

   // G2 output taps (stage numbers a,b) per PRN; invalid PRNs point both taps at
   // stage 1 so the index is always in range, and the chip is masked via valid.
   function automatic tap_pair_t prn_taps(input logic [5:0] prn);
      tap_pair_t  t;
      logic [7:0] ab;
      t.valid = 1'b1;
      case (prn)
         6'd1:    ab = 8'h26;
         6'd2:    ab = 8'h37;
         6'd3:    ab = 8'h48;
         6'd4:    ab = 8'h59;
         6'd5:    ab = 8'h19;
         6'd6:    ab = 8'h2a;
         6'd7:    ab = 8'h18;
         6'd8:    ab = 8'h29;
         6'd9:    ab = 8'h3a;
         6'd10:   ab = 8'h23;
         6'd11:   ab = 8'h34;
         6'd12:   ab = 8'h56;
         6'd13:   ab = 8'h67;
         6'd14:   ab = 8'h78;
         6'd15:   ab = 8'h89;
         6'd16:   ab = 8'h9a;
         6'd17:   ab = 8'h14;
         6'd18:   ab = 8'h25;
         6'd19:   ab = 8'h36;
         6'd20:   ab = 8'h47;
         6'd21:   ab = 8'h58;
         6'd22:   ab = 8'h69;
         6'd23:   ab = 8'h13;
         6'd24:   ab = 8'h46;
         6'd25:   ab = 8'h57;
         6'd26:   ab = 8'h68;
         6'd27:   ab = 8'h79;
         6'd28:   ab = 8'h8a;
         6'd29:   ab = 8'h16;
         6'd30:   ab = 8'h27;
         6'd31:   ab = 8'h38;
         6'd32:   ab = 8'h49;
         6'd33:   ab = 8'h5a;
         6'd34:   ab = 8'h4a;
         6'd35:   ab = 8'h17;
         6'd36:   ab = 8'h28;
         6'd37:   ab = 8'h4a;
         default: begin
            ab      = 8'h11;
            t.valid = 1'b0;
         end
      endcase
      t.a = ab[7:4];
      t.b = ab[3:0];
      return t;
   endfunction

endpackage

// File: rtl/ca_lfsr_pair.sv
// G1/G2 LFSR pair with a modulo-1023 phase counter; chip is combinational from state.
module ca_lfsr_pair
   import ca_code_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       advance,
   input  logic       reload,
   input  tap_pair_t  taps,
   output logic       chip,
   output logic [9:0] phase
);

   logic [10:1] g1_q, g1_d;
   logic [10:1] g2_q, g2_d;
   logic [9:0]  phase_q, phase_d;
   logic        g1_fb, g2_fb;

   always_comb begin
      g1_fb   = g1_q[3] ^ g1_q[10];
      g2_fb   = ^{g2_q[2], g2_q[3], g2_q[6], g2_q[8], g2_q[9], g2_q[10]};
      g1_d    = g1_q;
      g2_d    = g2_q;
      phase_d = phase_q;
      if (reload) begin
         g1_d    = LfsrInit;
         g2_d    = LfsrInit;
         phase_d = '0;
      end else if (advance) begin
         g1_d    = {g1_q[9:1], g1_fb};
         g2_d    = {g2_q[9:1], g2_fb};
         phase_d = (phase_q == 10'(CA_LEN - 1)) ? '0 : phase_q + 10'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         g1_q    <= LfsrInit;
         g2_q    <= LfsrInit;
         phase_q <= '0;
      end else begin
         g1_q    <= g1_d;
         g2_q    <= g2_d;
         phase_q <= phase_d;
      end
   end

   assign chip  = taps.valid & (g1_q[10] ^ g2_q[taps.a] ^ g2_q[taps.b]);
   assign phase = phase_q;

endmodule

// File: rtl/ca_code_epl_gen.sv
// GPS C/A code generator with slew control and early/prompt/late taps.
// Define CACODE_EPL_EN for the delay line and early/late outputs; otherwise only prompt is live.
module ca_code_epl_gen
   import ca_code_pkg::*;
#(
   parameter int unsigned SPACING = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] prn_num,
   input  logic       prn_load,
   input  logic       enb,
   input  logic       slew_en,
   input  logic [9:0] slew_chips,
   output logic       early,
   output logic       prompt,
   output logic       late,
   output logic [9:0] code_phase,
   output logic       epoch,
   output logic       busy,
   output logic       prn_valid
);

   logic [5:0]  prn_q;
   slew_state_e state_q, state_d;
   logic [9:0]  slew_cnt_q, slew_cnt_d;
   logic        advance, reload, chip, epoch_q, slew_ok;
   logic [9:0]  phase;
   tap_pair_t   taps;

   assign taps    = prn_taps(prn_q);
   assign slew_ok = (slew_chips != '0) && (slew_chips != 10'(CA_LEN));

   ca_lfsr_pair u_lfsr_pair (
      .clk     (clk),
      .rst     (rst),
      .advance (advance),
      .reload  (reload),
      .taps    (taps),
      .chip    (chip),
      .phase   (phase)
   );

   // prn_load outranks the slew step, which outranks enb; enb is dead while slewing.
   always_comb begin
      state_d    = state_q;
      slew_cnt_d = slew_cnt_q;
      advance    = 1'b0;
      reload     = 1'b0;
      if (prn_load) begin
         reload     = 1'b1;
         state_d    = StIdle;
         slew_cnt_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               advance = enb;
               if (slew_en && slew_ok) begin
                  state_d    = StSlew;
                  slew_cnt_d = slew_chips;
               end
            end
            StSlew: begin
               advance    = 1'b1;
               slew_cnt_d = slew_cnt_q - 10'd1;
               if (slew_cnt_q == 10'd1) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prn_q      <= '0;
         state_q    <= StIdle;
         slew_cnt_q <= '0;
         epoch_q    <= 1'b0;
      end else begin
         if (prn_load) begin
            prn_q <= prn_num;
         end
         state_q    <= state_d;
         slew_cnt_q <= slew_cnt_d;
         epoch_q    <= advance && (phase == 10'(CA_LEN - 1));
      end
   end

`ifdef CACODE_EPL_EN
   localparam int unsigned DlLen = 2 * SPACING;

   // dl_q[k] holds the chip at code_phase-1-k; cleared so taps read 0 until filled.
   logic [DlLen-1:0] dl_q;
   logic             early_q, prompt_q, late_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         dl_q     <= '0;
         early_q  <= 1'b0;
         prompt_q <= 1'b0;
         late_q   <= 1'b0;
      end else begin
         early_q  <= chip;
         prompt_q <= dl_q[SPACING-1];
         late_q   <= dl_q[DlLen-1];
         if (reload) begin
            dl_q <= '0;
         end else if (advance) begin
            dl_q <= {dl_q[DlLen-2:0], chip};
         end
      end
   end

   assign early  = early_q;
   assign prompt = prompt_q;
   assign late   = late_q;
`else
   logic       prompt_q;
   logic [2:0] unused_spacing;

   assign unused_spacing = 3'(SPACING);

   always_ff @(posedge clk) begin
      if (rst) begin
         prompt_q <= 1'b0;
      end else begin
         prompt_q <= chip;
      end
   end

   assign early  = 1'b0;
   assign prompt = prompt_q;
   assign late   = 1'b0;
`endif

   assign code_phase = phase;
   assign epoch      = epoch_q;
   assign busy       = (state_q == StSlew);
   assign prn_valid  = taps.valid;

endmodule

// File: tb/tb_ca_code_epl_gen.sv
// Randomised bench for ca_code_epl_gen against a code-table reference model.
module tb_ca_code_epl_gen;

   localparam int unsigned SP = 2;

   logic       clk, rst, prn_load, enb, slew_en;
   logic [5:0] prn_num;
   logic [9:0] slew_chips;
   logic       early, prompt, late, epoch, busy, prn_valid;
   logic [9:0] code_phase;
   logic [15:0] dut_vec;
   logic       main_chip;

   ca_code_epl_gen #(.SPACING(SP)) dut (
      .clk        (clk),
      .rst        (rst),
      .prn_num    (prn_num),
      .prn_load   (prn_load),
      .enb        (enb),
      .slew_en    (slew_en),
      .slew_chips (slew_chips),
      .early      (early),
      .prompt     (prompt),
      .late       (late),
      .code_phase (code_phase),
      .epoch      (epoch),
      .busy       (busy),
      .prn_valid  (prn_valid)
   );

   assign dut_vec = {early, prompt, late, epoch, busy, prn_valid, code_phase};
`ifdef CACODE_EPL_EN
   assign main_chip = early;
`else
   assign main_chip = prompt;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Reference code tables: G1 output and G2 state for every phase.
   bit          g1o[1023];
   bit [10:1]   g2h[1023];
   int tap_a[38] = '{0,2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4,5,4,1,2,4};
   int tap_b[38] = '{0,6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9,10,
                     10,7,8,10};

   // Model state: latched PRN, phase, advances since load, remaining slew advances.
   int m_prn, m_phase, m_nadv, m_slew;
   bit x_early, x_prompt, x_late, x_epoch;

   task automatic build_code();
      bit [10:1] g1, g2;
      bit f1, f2;
      g1 = '1;
      g2 = '1;
      for (int n = 0; n < 1023; n++) begin
         g1o[n] = g1[10];
         g2h[n] = g2;
         f1 = g1[3] ^ g1[10];
         f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
         g1 = {g1[9:1], f1};
         g2 = {g2[9:1], f2};
      end
   endtask

   function automatic bit chip_of(input int prn, input int n);
      bit [10:1] s;
      if (prn < 1 || prn > 37) return 1'b0;
      s = g2h[n];
      return g1o[n] ^ s[tap_a[prn]] ^ s[tap_b[prn]];
   endfunction

   function automatic logic [15:0] exp_vec();
      return {x_early, x_prompt, x_late, x_epoch, (m_slew > 0), (m_prn >= 1 && m_prn <= 37),
              10'(m_phase)};
   endfunction

   // Drive one cycle of inputs, advance the model across the edge, land 1 time unit after it.
   task automatic cycle(input bit r, input bit ld, input bit [5:0] p, input bit e, input bit se,
                        input bit [9:0] sc);
      bit c_now, adv;
      rst = r; prn_load = ld; prn_num = p; enb = e; slew_en = se; slew_chips = sc;
      c_now = chip_of(m_prn, m_phase);
`ifdef CACODE_EPL_EN
      x_early  = c_now;
      x_prompt = (m_nadv >= SP) ? chip_of(m_prn, (m_phase + 1023 - SP) % 1023) : 1'b0;
      x_late   = (m_nadv >= 2 * SP) ? chip_of(m_prn, (m_phase + 1023 - 2 * SP) % 1023) : 1'b0;
`else
      x_early  = 1'b0;
      x_prompt = c_now;
      x_late   = 1'b0;
`endif
      x_epoch = 1'b0;
      adv     = 1'b0;
      if (r) begin
         m_prn = 0; m_phase = 0; m_nadv = 0; m_slew = 0;
         x_early = 1'b0; x_prompt = 1'b0; x_late = 1'b0;
      end else if (ld) begin
         m_prn = int'(p); m_phase = 0; m_nadv = 0; m_slew = 0;
      end else begin
         if (m_slew > 0) begin
            adv = 1'b1;
            m_slew--;
         end else begin
            adv = e;
            if (se && sc > 0 && sc < 1023) m_slew = int'(sc);
         end
         if (adv) begin
            x_epoch = (m_phase == 1022);
            m_phase = (m_phase + 1) % 1023;
            if (m_nadv < 100) m_nadv++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 6'd3, 1, 1, 10'd5);
      n_tests++;
      if (dut_vec !== 16'h0) begin
         n_fail++; $display("FAIL reset_zero got %h want %h", dut_vec, 16'h0);
      end
      cycle(0, 0, 0, 0, 0, 0);
      n_tests++;
      if (dut_vec !== exp_vec()) begin
         n_fail++; $display("FAIL reset_idle got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_prn_prefix(input int prn, input bit [9:0] want);
      bit [9:0] got = '0;
      cycle(0, 1, 6'(prn), 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cycle(0, 0, 0, 1, 0, 0);
         got = {got[8:0], main_chip};
         n_tests++;
         if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL prefix_cyc%0d got %h want %h", i, dut_vec, exp_vec());
         end
      end
      n_tests++;
      if (got !== want) begin
         n_fail++; $display("FAIL prefix_prn%0d got %b want %b", prn, got, want);
      end
   endtask

   task automatic test_epoch();
      int n_ep = 0;
      cycle(0, 1, 6'd1, 0, 0, 0);
      for (int i = 0; i < 2046; i++) begin
         cycle(0, 0, 0, 1, 0, 0);
         n_tests++;
         if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL epoch_run cyc %0d got %h want %h", i, dut_vec, exp_vec());
         end
         if (epoch === 1'b1) begin
            n_ep++;
            n_tests++;
            if (code_phase !== 10'd0) begin
               n_fail++; $display("FAIL epoch_phase got %0d want 0", code_phase);
            end
         end
         if (i == 1022) begin
            n_tests++;
            if (n_ep != 1) begin
               n_fail++; $display("FAIL epoch_once got %0d want 1", n_ep);
            end
         end
      end
      n_tests++;
      if (n_ep != 2) begin
         n_fail++; $display("FAIL epoch_twice got %0d want 2", n_ep);
      end
   endtask

   task automatic test_slew_100();
      int k, n_busy;
      k = $urandom_range(0, 40);
      cycle(0, 1, 6'($urandom_range(1, 37)), 0, 0, 0);
      repeat (k) cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 1, 10'd100);
      n_busy = 0;
      for (int i = 0; i < 200 && busy === 1'b1; i++) begin
         cycle(0, 0, 0, $urandom_range(0, 1) == 1, 0, 0);
         n_busy++;
         n_tests++;
         if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL slew100_cyc%0d got %h want %h", i, dut_vec, exp_vec());
         end
      end
      n_tests++;
      if (n_busy != 100) begin
         n_fail++; $display("FAIL slew100_busy got %0d want 100", n_busy);
      end
      n_tests++;
      if (code_phase !== 10'(k + 100)) begin
         n_fail++; $display("FAIL slew100_phase got %0d want %0d", code_phase, k + 100);
      end
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 0, 1, 0, 0);
         n_tests++;
         if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL slew100_after got %h want %h", dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_slew_bounds();
      int vals[6] = '{1, 1022, 0, 1023, 37, 500};
      foreach (vals[j]) begin
         cycle(0, 0, 0, $urandom_range(0, 1) == 1, 1, 10'(vals[j]));
         n_tests++;
         if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL slewb_start%0d got %h want %h", vals[j], dut_vec, exp_vec());
         end
         for (int i = 0; i < 1100 && busy === 1'b1; i++) begin
            cycle(0, 0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  10'($urandom_range(1, 900)));
            n_tests++;
            if (dut_vec !== exp_vec()) begin
               n_fail++; $display("FAIL slewb_run%0d got %h want %h", vals[j], dut_vec, exp_vec());
            end
         end
         n_tests++;
         if (busy !== 1'b0) begin
            n_fail++; $display("FAIL slewb_done%0d got %b want 0", vals[j], busy);
         end
      end
   endtask

   task automatic test_slew_abort();
      bit [9:0] got = '0, want = '0;
      cycle(0, 1, 6'd5, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 10'd300);
      for (int i = 1; i < 50; i++) begin
         cycle(0, 0, 0, 1, 0, 0);
         n_tests++;
         if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL abort_slew got %h want %h", dut_vec, exp_vec());
         end
      end
      n_tests++;
      if (code_phase !== 10'd49) begin
         n_fail++; $display("FAIL abort_enb_ignored got %0d want 49", code_phase);
      end
      cycle(0, 1, 6'd9, 1, 0, 0);
      n_tests++;
      if (busy !== 1'b0 || code_phase !== 10'd0) begin
         n_fail++; $display("FAIL abort_load got busy %b phase %0d want 0 0", busy, code_phase);
      end
      for (int i = 0; i < 10; i++) begin
         cycle(0, 0, 0, 1, 0, 0);
         got  = {got[8:0], main_chip};
         want = {want[8:0], chip_of(9, i)};
      end
      n_tests++;
      if (got !== want) begin
         n_fail++; $display("FAIL abort_newprn got %b want %b", got, want);
      end
   endtask

   task automatic test_taps();
      cycle(0, 1, 6'd7, 0, 0, 0);
      for (int i = 0; i < 12; i++) begin
         cycle(0, 0, 0, 1, 0, 0);
         n_tests++;
`ifdef CACODE_EPL_EN
         if (early !== chip_of(7, i)
             || prompt !== ((i >= 2) ? chip_of(7, i - 2) : 1'b0)
             || late !== ((i >= 4) ? chip_of(7, i - 4) : 1'b0)) begin
            n_fail++; $display("FAIL taps_cyc%0d got e%b p%b l%b", i, early, prompt, late);
         end
`else
         if (early !== 1'b0 || late !== 1'b0 || prompt !== chip_of(7, i)) begin
            n_fail++; $display("FAIL taps_cyc%0d got e%b p%b l%b", i, early, prompt, late);
         end
`endif
      end
   endtask

   task automatic test_invalid_prn(input int prn);
      int n_ep = 0;
      bit any_chip = 1'b0;
      cycle(0, 1, 6'(prn), 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 10'd1000);
      for (int i = 0; i < 1100 && busy === 1'b1; i++) begin
         cycle(0, 0, 0, 0, 0, 0);
         any_chip |= early | prompt | late;
      end
      for (int i = 0; i < 40; i++) begin
         cycle(0, 0, 0, 1, 0, 0);
         any_chip |= early | prompt | late;
         if (epoch === 1'b1) n_ep++;
         n_tests++;
         if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL inval%0d_cyc got %h want %h", prn, dut_vec, exp_vec());
         end
      end
      n_tests++;
      if (n_ep != 1 || any_chip !== 1'b0 || prn_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL inval%0d got ep %0d chip %b valid %b want 1 0 0", prn, n_ep, any_chip,
                  prn_valid);
      end
   endtask

   task automatic test_rst_mid_slew();
      cycle(0, 1, 6'd3, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 10'd500);
      repeat (20) cycle(0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 0, 0, 0, 0);
         n_tests++;
         if (busy !== 1'b0 || code_phase !== 10'd0 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL rst_slew got %h want %h", dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      bit [9:0] sc;
      int r;
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 9);
         sc = (r == 0) ? 10'd0 : (r == 1) ? 10'd1023 : 10'($urandom_range(1, 80));
         cycle($urandom_range(0, 499) == 0, $urandom_range(0, 99) == 0,
               6'($urandom_range(0, 63)), $urandom_range(0, 1) == 1,
               $urandom_range(0, 29) == 0, sc);
         n_tests++;
         if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL random_cyc%0d got %h want %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   initial begin
      rst = 1'b0; prn_load = 1'b0; enb = 1'b0; slew_en = 1'b0;
      prn_num = '0; slew_chips = '0;
      m_prn = 0; m_phase = 0; m_nadv = 0; m_slew = 0;
      x_early = 1'b0; x_prompt = 1'b0; x_late = 1'b0; x_epoch = 1'b0;
      build_code();
      test_reset();
      test_prn_prefix(1, 10'b1100100000);
      test_prn_prefix(2, 10'b1110010000);
      test_epoch();
      test_slew_100();
      test_slew_bounds();
      test_slew_abort();
      test_taps();
      test_invalid_prn(0);
      test_invalid_prn(40);
      test_rst_mid_slew();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ca_code_epl_gen.md
CA_CODE_EPL_GEN -- requirements
Module: ca_code_epl_gen

Interface
REQ-001 SHALL have parameter SPACING, default 1, range 1..4: early/prompt and prompt/late separation in chips.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port prn_num  input  6  SV PRN number, sampled only on prn_load.
REQ-005 SHALL have port prn_load  input  1  one-cycle pulse: latch prn_num and restart code.
REQ-006 SHALL have port enb  input  1  advance code one chip.
REQ-007 SHALL have port slew_en  input  1  one-cycle pulse: start slew of slew_chips.
REQ-008 SHALL have port slew_chips  input  10  number of chips to skip.
REQ-009 SHALL have ports early, prompt, late  output  1 each  registered code chips.
REQ-010 SHALL have port code_phase  output  10  current chip index 0..1022.
REQ-011 SHALL have port epoch  output  1  one-cycle pulse on code wrap.
REQ-012 SHALL have ports busy and prn_valid  output  1 each  slew in progress; latched PRN in 1..37.

Function
REQ-013 SHALL keep G1 (taps 3,10) and G2 (taps 2,3,6,8,9,10) 10-bit LFSRs, both all-ones at code_phase 0.
REQ-014 SHALL form chip c = G1[10] xor G2[a] xor G2[b], with (a,b) per the IS-GPS-200 tap table for PRN 1..37; c = 0 for PRN 0 or 38..63.
REQ-015 SHALL perform one "advance" per cycle: shift both LFSRs, code_phase +1 modulo 1023, shift c into the delay line.
REQ-016 SHALL resolve per-cycle priority as rst > prn_load > slew step > enb; enb is ignored while busy = 1.
REQ-017 SHALL, on prn_load: latch prn_num, reload LFSRs to all-ones, set code_phase 0, clear the delay line, abort any slew (busy 0).
REQ-018 SHALL run slew FSM IDLE->SLEW on slew_en in IDLE with slew_chips in 1..1022; SLEW performs one advance per cycle and returns to IDLE after slew_chips advances.
REQ-019 SHALL treat slew_chips of 0 or 1023 as a no-op, and SHALL ignore slew_en while busy = 1.
REQ-020 SHALL hold busy = 1 exactly in the cycles the FSM is in SLEW.
REQ-021 SHALL register early <= c(code_phase), giving 1-cycle latency from state change to output.
REQ-022 SHALL register prompt <= c(code_phase - SPACING) and late <= c(code_phase - 2*SPACING), both taken from the delay line.
REQ-023 SHALL drive prompt and late as 0 until SPACING and 2*SPACING advances respectively have occurred since reset or prn_load.
REQ-024 SHALL pulse epoch for 1 cycle, coincident with code_phase = 0, after any advance 1022->0 (enb or slew).
REQ-025 SHALL keep LFSRs stepping under an invalid PRN, with prn_valid = 0 and all chips 0.

Reset
REQ-026 SHALL, on rst: set LFSRs to all-ones, latched PRN 0, code_phase 0, delay line 0, FSM IDLE, and every output 0.
REQ-027 SHALL, on rst asserted mid-slew, abort the slew with no further advances.

Configuration
REQ-028 SHALL use macro CACODE_EPL_EN: defined means delay line present and early/prompt/late as in REQ-021..023.
REQ-029 SHALL, when CACODE_EPL_EN is undefined: omit the delay line, drive early and late as constant 0, and register prompt <= c(code_phase) with 1-cycle latency.

Structure
REQ-030 SHALL place in package ca_code_pkg: CA_LEN = 1023, LFSR init constant, PRN-to-tap-pair lookup function, slew FSM state typedef.
REQ-031 SHALL implement LFSR pair plus phase counter as sub-module ca_lfsr_pair (inputs: advance, reload, tap pair; outputs: chip, phase).

Verification
REQ-032 SHALL cover: prn_load PRN 1, 10 enb cycles -> early sequence 1100100000 (octal 1440); PRN 2 -> 1110010000.
REQ-033 SHALL cover: PRN 1, 1023 enb -> epoch once, with code_phase 0; 2046 enb -> epoch twice; sequence repeats exactly.
REQ-034 SHALL cover: slew_chips 100 -> busy high 100 cycles; afterwards code_phase = 100 and early matches a reference run after 100 enb.
REQ-035 SHALL cover: SPACING 2 -> prompt equals early delayed 2 advances, late delayed 4; first 2 and 4 values respectively are 0.
REQ-036 SHALL cover: prn_load at slew cycle 50 -> busy 0 next cycle, code_phase 0, new PRN sequence from chip 0; enb during busy has no effect.
REQ-037 SHALL cover: prn_num 0 and 40 -> prn_valid 0, all chips 0, code_phase still counts and epoch still fires.
